mem_access_ctrl: RTL and testbench

- Sequencer and arbiter for the shared data memory path in the multicycle CPU: memory array, MAR, MDR and the DM/MDR output enables.
- Two requesters share the single memory:
  - port 0: instruction fetch.
  - port 1: load/store unit.
- Arbitrates between them round-robin and runs one access at a time through address, strobe, capture and done phases.
- Generates the MAR/MDR write enables and the read/write strobes the memory needs, and returns the read data with a one-cycle done pulse.

---
 rtl/mem_access_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequencer and round-robin arbiter for the shared data memory of the
//   multicycle CPU. Port 0 is instruction fetch and port 1 is the load/store
//   unit. Each access runs one at a time through the phases
//   ADDR -> STROBE -> CAPTURE (reads only) -> DONE. An out-of-range address
//   skips straight to DONE with err set.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req0, addr0         fetch request (held until done0) and word address
//   req1, we1, addr1,   load/store request (held until done1), store flag,
//   wdata1              word address and store data
//   done0, done1        one-cycle completion pulse per port
//   err                 valid with the done pulse: address out of range
//   rdata               read data, valid at done, held until the next capture
//   busy                high from the cycle after accept through done
//   dm_addr, dm_wdata   memory address / write data (stable for the access)
//   dm_r, dm_w          memory read / write strobes (STROBE_CYCLES long)
//   dm_rdata            memory read data
//   mar_wr, mdr_wr      MAR / MDR write enables
//   mem_oe              DM output enable toward the bus
module mem_access_ctrl #(
   parameter int STROBE_CYCLES = 2,
   parameter int ADDR_BITS     = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic [31:0] addr0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        done0,
   output logic        done1,
   output logic        err,
   output logic [31:0] rdata,
   output logic        busy,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic        dm_r,
   output logic        dm_w,
   input  logic [31:0] dm_rdata,
   output logic        mar_wr,
   output logic        mdr_wr,
   output logic        mem_oe
);

   localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, ADDR, STROBE, CAPTURE, DONE} state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        owner_q, owner_d;
   logic        we_q, we_d;
   logic        aerr_q, aerr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        done0_q, done0_d;
   logic        done1_q, done1_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic        dm_r_q, dm_r_d;
   logic        dm_w_q, dm_w_d;
   logic        mar_wr_q, mar_wr_d;
   logic        mdr_wr_q, mdr_wr_d;
   logic        mem_oe_q, mem_oe_d;
   logic        win;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      we_d    = we_q;
      aerr_d  = aerr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      win     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // On a tie the port that did not win last time is served.
               win     = (req0 && req1) ? ~last_q : req1;
               last_d  = win;
               owner_d = win;
               addr_d  = win ? addr1 : addr0;
               we_d    = win & we1;
               wdata_d = win ? wdata1 : 32'd0;
               aerr_d  = (addr_d >> ADDR_BITS) != 32'd0;
               state_d = aerr_d ? DONE : ADDR;
            end
         end
         ADDR: begin
            cnt_d   = '0;
            state_d = STROBE;
         end
         STROBE: begin
            if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
               state_d = we_q ? DONE : CAPTURE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CAPTURE: begin
            rdata_d = dm_rdata;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so that the registered
      // copies line up exactly with the state they belong to.
      busy_d   = (state_d != IDLE);
      mar_wr_d = (state_d == ADDR);
      dm_r_d   = (state_d == STROBE) && !we_d;
      dm_w_d   = (state_d == STROBE) &&  we_d;
      mdr_wr_d = (state_d == CAPTURE);
      mem_oe_d = (state_d == CAPTURE);
      done0_d  = (state_d == DONE) && !owner_d;
      done1_d  = (state_d == DONE) &&  owner_d;
      err_d    = (state_d == DONE) &&  aerr_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         aerr_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         cnt_q    <= '0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         dm_r_q   <= 1'b0;
         dm_w_q   <= 1'b0;
         mar_wr_q <= 1'b0;
         mdr_wr_q <= 1'b0;
         mem_oe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         aerr_q   <= aerr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         dm_r_q   <= dm_r_d;
         dm_w_q   <= dm_w_d;
         mar_wr_q <= mar_wr_d;
         mdr_wr_q <= mdr_wr_d;
         mem_oe_q <= mem_oe_d;
      end
   end

   assign done0    = done0_q;
   assign done1    = done1_q;
   assign err      = err_q;
   assign rdata    = rdata_q;
   assign busy     = busy_q;
   assign dm_addr  = addr_q;
   assign dm_wdata = wdata_q;
   assign dm_r     = dm_r_q;
   assign dm_w     = dm_w_q;
   assign mar_wr   = mar_wr_q;
   assign mdr_wr   = mdr_wr_q;
   assign mem_oe   = mem_oe_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Self-checking bench for mem_access_ctrl: a directed vector table, hand
//   written multi-cycle sequences (drop request, tie from reset, reset in the
//   middle of a store) and a randomized phase checked against a transaction
//   level reference model (reference memory, round-robin pointer, latency
//   formula).
module tb_mem_access_ctrl;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wdata1 = '0;
   logic        done0, done1, err, busy, dm_r, dm_w, mar_wr, mdr_wr, mem_oe;
   logic [31:0] rdata, dm_addr, dm_wdata;
   logic [31:0] dm_rdata = '0;

   mem_access_ctrl #(.STROBE_CYCLES(S), .ADDR_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .addr0(addr0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .done0(done0), .done1(done1), .err(err), .rdata(rdata), .busy(busy),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_r(dm_r), .dm_w(dm_w),
      .dm_rdata(dm_rdata), .mar_wr(mar_wr), .mdr_wr(mdr_wr), .mem_oe(mem_oe)
   );

   always #5 clk = ~clk;

   // Memory device: a read is launched and a write committed on the strobe's
   // rising edge.
   logic [31:0] mem [256];
   int r_rise = 0, w_rise = 0, overlap = 0;
   always @(posedge dm_r) begin
      dm_rdata = mem[dm_addr[7:0]];
      r_rise++;
   end
   always @(posedge dm_w) begin
      mem[dm_addr[7:0]] = dm_wdata;
      w_rise++;
   end
   always @(negedge clk) if (dm_r && dm_w) overlap++;

   // Reference model state.
   logic [31:0] ref_mem [256];
   logic [31:0] ref_rdata = '0;
   logic        ref_last  = 1'b1;

   int tests = 0, fails = 0;

   int st_mar, st_rcyc, st_wcyc, st_mdr, st_oe_mis, st_busy_bad, st_both;
   int st_first_mar, st_first_stb, st_first_mdr, st_r_rise, st_w_rise;

   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called in the accept cycle (numbered start); returns the finishing port
   // (-1 on timeout) and the cycle number of the done pulse.
   task automatic wait_done(input int start, output int port, output int cyc);
      int r0, w0;
      r0 = r_rise; w0 = w_rise;
      st_mar = 0; st_rcyc = 0; st_wcyc = 0; st_mdr = 0; st_oe_mis = 0;
      st_busy_bad = 0; st_both = 0;
      st_first_mar = 0; st_first_stb = 0; st_first_mdr = 0;
      cyc = start; port = -1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         cyc++;
         if (!busy) st_busy_bad++;
         if (mar_wr) begin st_mar++; if (st_first_mar == 0) st_first_mar = cyc; end
         if (dm_r) begin st_rcyc++; if (st_first_stb == 0) st_first_stb = cyc; end
         if (dm_w) begin st_wcyc++; if (st_first_stb == 0) st_first_stb = cyc; end
         if (mdr_wr) begin st_mdr++; if (st_first_mdr == 0) st_first_mdr = cyc; end
         if (mem_oe != mdr_wr) st_oe_mis++;
         if (done0 || done1) begin
            if (done0 && done1) st_both++;
            port = done1 ? 1 : 0;
            break;
         end
      end
      st_r_rise = r_rise - r0;
      st_w_rise = w_rise - w0;
      if (port < 0) begin
         tests++; fails++;
         $display("FAIL done_timeout: got no done pulse, expected one within 40 cycles");
      end
   endtask

   // Transaction-level expectations, then update of the reference model.
   task automatic check_txn(input string tag, input int port, input int cyc, input int exp_port,
                            input logic we, input logic [31:0] addr, input logic [31:0] wd);
      logic e;
      int   lat;
      e   = (addr[31:8] != 24'd0);
      lat = e ? 2 : (we ? S + 3 : S + 4);
      if (!e && !we) ref_rdata = ref_mem[addr[7:0]];
      if (!e && we) ref_mem[addr[7:0]] = wd;
      ref_last = exp_port[0];
      check({tag, " port"}, 32'(port), 32'(exp_port));
      check({tag, " latency"}, 32'(cyc), 32'(lat));
      check({tag, " err"}, 32'(err), 32'(e));
      check({tag, " rdata"}, rdata, ref_rdata);
      check({tag, " mar_wr cycles"}, 32'(st_mar), (e ? 32'd0 : 32'd1));
      check({tag, " dm_r edges"}, 32'(st_r_rise), ((!e && !we) ? 32'd1 : 32'd0));
      check({tag, " dm_w edges"}, 32'(st_w_rise), ((!e && we) ? 32'd1 : 32'd0));
      check({tag, " strobe cycles"}, 32'(st_rcyc + st_wcyc), (e ? 32'd0 : 32'(S)));
      check({tag, " mdr_wr cycles"}, 32'(st_mdr), ((!e && !we) ? 32'd1 : 32'd0));
      check({tag, " busy/oe/done anomalies"}, 32'(st_busy_bad + st_oe_mis + st_both), 32'd0);
      if (!e) begin
         check({tag, " mar_wr cycle"}, 32'(st_first_mar), 32'd2);
         check({tag, " strobe start cycle"}, 32'(st_first_stb), 32'd3);
         if (!we) check({tag, " mdr_wr cycle"}, 32'(st_first_mdr), 32'(S + 3));
      end
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 7) == 0) return $urandom | 32'h0000_0100;
      return 32'($urandom_range(0, 255));
   endfunction

   initial begin
      int p, c, n_done;
      logic r0, r1, exp_p, seen;
      logic [31:0] a0, a1, wd;
      logic w1;

      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'hC0DE_0000 | 32'(i);
         ref_mem[i] = 32'hC0DE_0000 | 32'(i);
      end
      mem[3] = 32'h1234_5678; ref_mem[3] = 32'h1234_5678;

      vecs[0] = '{1'b0, 1'b0, 32'd3,         32'd0,         1'b0, 32'h1234_5678, 6};
      vecs[1] = '{1'b1, 1'b1, 32'd16,        32'hDEAD_BEEF, 1'b0, 32'h1234_5678, 5};
      vecs[2] = '{1'b1, 1'b0, 32'd16,        32'd0,         1'b0, 32'hDEAD_BEEF, 6};
      vecs[3] = '{1'b1, 1'b1, 32'h100,       32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF, 2};
      vecs[4] = '{1'b0, 1'b0, 32'd0,         32'd0,         1'b0, 32'hC0DE_0000, 6};
      vecs[5] = '{1'b1, 1'b0, 32'd255,       32'd0,         1'b0, 32'hC0DE_00FF, 6};
      vecs[6] = '{1'b0, 1'b0, 32'h8000_0003, 32'd0,         1'b1, 32'hC0DE_00FF, 2};
      vecs[7] = '{1'b0, 1'b0, 32'd16,        32'd0,         1'b0, 32'hDEAD_BEEF, 6};

      // Reset state: checked before the first clock edge (asynchronous).
      #2 rst_n = 1'b0;
      #1;
      check("reset ctrl outputs", 32'({done0, done1, err, busy, dm_r, dm_w, mar_wr, mdr_wr, mem_oe}), 32'd0);
      check("reset rdata", rdata, 32'd0);
      check("reset dm_addr", dm_addr, 32'd0);
      check("reset dm_wdata", dm_wdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle busy", 32'(busy), 32'd0);

      // Directed vector table, one port at a time.
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].port) begin
            req1 = 1'b1; we1 = vecs[i].we; addr1 = vecs[i].addr; wdata1 = vecs[i].wdata;
         end else begin
            req0 = 1'b1; addr0 = vecs[i].addr;
         end
         wait_done(1, p, c);
         check($sformatf("vec%0d port", i), 32'(p), 32'(vecs[i].port));
         check($sformatf("vec%0d latency", i), 32'(c), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
         check_txn($sformatf("vec%0d", i), p, c, 32'(vecs[i].port), vecs[i].port & vecs[i].we,
                   vecs[i].addr, vecs[i].wdata);
         req0 = 1'b0; req1 = 1'b0;
         @(posedge clk); #1;
      end
      check("out-of-range store left mem[0]", mem[0], 32'hC0DE_0000);

      // Drop request in the ADDR cycle: the access still completes once.
      addr0 = 32'd7; req0 = 1'b1;
      @(posedge clk); #1;
      check("drop mar_wr in cycle 2", 32'(mar_wr), 32'd1);
      req0 = 1'b0;
      wait_done(2, p, c);
      check("drop port", 32'(p), 32'd0);
      check("drop latency", 32'(c), 32'(S + 4));
      check("drop rdata", rdata, 32'hC0DE_0007);
      ref_rdata = 32'hC0DE_0007; ref_last = 1'b0;
      n_done = 0;
      repeat (6) begin @(posedge clk); #1; if (done0 || done1) n_done++; end
      check("drop extra done pulses", 32'(n_done), 32'd0);

      // Tie from reset: both requests held continuously -> 0,1,0,1.
      rst_n = 1'b0;
      addr0 = 32'd5; addr1 = 32'd6; we1 = 1'b0; req0 = 1'b1; req1 = 1'b1;
      ref_last = 1'b1; ref_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_done(1, p, c);
         check_txn($sformatf("tie%0d", k), p, c, k % 2, 1'b0, (k % 2) ? addr1 : addr0, 32'd0);
         @(posedge clk); #1;
      end
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;

      // Reset while dm_w is high: strobe drops at once, no done pulse.
      addr1 = 32'd20; we1 = 1'b1; wdata1 = 32'h5A5A_1234; req1 = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (dm_w) begin seen = 1'b1; break; end
      end
      check("rst test dm_w reached", 32'(seen), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst async outputs", 32'({dm_w, dm_r, busy, done1, mar_wr}), 32'd0);
      req1 = 1'b0;
      @(posedge clk); #1;
      check("rst no done", 32'({done0, done1}), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst busy after release", 32'(busy), 32'd0);
      ref_last = 1'b1; ref_rdata = '0;
      ref_mem[20] = 32'h5A5A_1234;   // its rising edge already reached memory
      addr0 = 32'd20; req0 = 1'b1;
      wait_done(1, p, c);
      check_txn("post-rst read", p, c, 0, 1'b0, 32'd20, 32'd0);
      req0 = 1'b0;
      @(posedge clk); #1;

      // Randomized traffic against the reference model.
      for (int it = 0; it < 40; it++) begin
         int pat;
         pat = int'($urandom_range(0, 2));
         r0 = (pat != 1); r1 = (pat != 0);
         a0 = rand_addr(); a1 = rand_addr(); wd = $urandom; w1 = 1'(($urandom & 1));
         addr0 = a0; addr1 = a1; wdata1 = wd; we1 = w1;
         req0 = r0; req1 = r1;
         exp_p = (r0 && r1) ? ~ref_last : r1;
         wait_done(1, p, c);
         check_txn($sformatf("rnd%0d", it), p, c, 32'(exp_p), exp_p & w1, exp_p ? a1 : a0, wd);
         if (p == 1) req1 = 1'b0;
         else if (p == 0) req0 = 1'b0;
         else begin req0 = 1'b0; req1 = 1'b0; end
         @(posedge clk); #1;
         if (req0 || req1) begin
            exp_p = req1;
            wait_done(1, p, c);
            check_txn($sformatf("rnd%0d second", it), p, c, 32'(exp_p), exp_p & w1,
                      exp_p ? a1 : a0, wd);
            req0 = 1'b0; req1 = 1'b0;
            @(posedge clk); #1;
         end
      end

      check("dm_r/dm_w overlap cycles", 32'(overlap), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
